// File: rtl/control_pkg.sv
// ============================================================================
// Module      : control_pkg
// Description : Shared opcodes, control-word field indices, ALU codes and the
//               phase encoding for the Mini-SRC hardwired control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_pkg;

    localparam int STEP_W = 3;

    localparam logic [1:0] PH_FETCH = 2'd0;
    localparam logic [1:0] PH_EXEC  = 2'd1;
    localparam logic [1:0] PH_HALT  = 2'd2;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_INC = 5'b11111;

    localparam int EN_HI  = 16;
    localparam int EN_LO  = 17;
    localparam int EN_Z   = 18;
    localparam int EN_Y   = 19;
    localparam int EN_PC  = 20;
    localparam int EN_MDR = 21;
    localparam int EN_IR  = 24;
    localparam int EN_MAR = 25;
    localparam int EN_OUT = 26;
    localparam int EN_CON = 27;

    localparam int BS_HI  = 16;
    localparam int BS_LO  = 17;
    localparam int BS_ZHI = 18;
    localparam int BS_ZLO = 19;
    localparam int BS_PC  = 20;
    localparam int BS_MDR = 21;
    localparam int BS_INP = 22;
    localparam int BS_C   = 23;

    typedef struct packed {
        logic [31:0] enable;
        logic [31:0] bus_select;
        logic        gra;
        logic        grb;
        logic        grc;
        logic        rin;
        logic        rout;
        logic        baout;
        logic        read_ram;
        logic        write_ram;
        logic        md_read;
        logic [4:0]  alu_op;
    } ctrl_word_t;

    function automatic logic is_r_alu(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    function automatic logic is_i_alu(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_step_decode.sv
// ============================================================================
// Module      : control_step_decode
// Description : Combinational map from (phase, step, opcode, CONFF) to the
//               control word, plus a flag marking the last step of the phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_step_decode
    import control_pkg::*;
#(
    parameter int RAM_WAIT = 1
) (
    input  logic [1:0]        phase_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [4:0]        opcode_i,
    input  logic              conff_i,
    output ctrl_word_t        ctrl_o,
    output logic              last_o
);

    localparam logic [STEP_W-1:0] FETCH_TM   = STEP_W'(1 + RAM_WAIT);
    localparam logic [STEP_W-1:0] FETCH_LAST = STEP_W'(2 + RAM_WAIT);
    localparam logic [STEP_W-1:0] LD_CAP     = STEP_W'(3 + RAM_WAIT);
    localparam logic [STEP_W-1:0] LD_LAST    = STEP_W'(4 + RAM_WAIT);

    always_comb begin
        ctrl_o = '0;
        last_o = 1'b0;
        case (phase_i)
            PH_FETCH: begin
                if (step_i == STEP_W'(0)) begin
                    ctrl_o.bus_select[BS_PC] = 1'b1;
                    ctrl_o.enable[EN_MAR]    = 1'b1;
                    ctrl_o.enable[EN_Z]      = 1'b1;
                    ctrl_o.alu_op            = ALU_INC;
                end else if (step_i == STEP_W'(1)) begin
                    ctrl_o.bus_select[BS_ZLO] = 1'b1;
                    ctrl_o.enable[EN_PC]      = 1'b1;
                    ctrl_o.read_ram           = 1'b1;
                end else if (step_i < FETCH_TM) begin
                    ctrl_o.read_ram = 1'b1;
                end else if (step_i == FETCH_TM) begin
                    ctrl_o.read_ram       = 1'b1;
                    ctrl_o.md_read        = 1'b1;
                    ctrl_o.enable[EN_MDR] = 1'b1;
                end else begin
                    ctrl_o.bus_select[BS_MDR] = 1'b1;
                    ctrl_o.enable[EN_IR]      = 1'b1;
                    last_o                    = (step_i == FETCH_LAST);
                end
            end
            PH_EXEC: begin
                if (is_r_alu(opcode_i) || is_i_alu(opcode_i)) begin
                    case (step_i)
                        STEP_W'(0): begin
                            ctrl_o.grb          = 1'b1;
                            ctrl_o.rout         = 1'b1;
                            ctrl_o.enable[EN_Y] = 1'b1;
                        end
                        STEP_W'(1): begin
                            if (is_i_alu(opcode_i)) begin
                                ctrl_o.bus_select[BS_C] = 1'b1;
                            end else begin
                                ctrl_o.grc  = 1'b1;
                                ctrl_o.rout = 1'b1;
                            end
                            ctrl_o.alu_op       = opcode_i;
                            ctrl_o.enable[EN_Z] = 1'b1;
                        end
                        STEP_W'(2): begin
                            ctrl_o.bus_select[BS_ZLO] = 1'b1;
                            ctrl_o.gra                = 1'b1;
                            ctrl_o.rin                = 1'b1;
                            last_o                    = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    case (opcode_i)
                        OP_MUL, OP_DIV: begin
                            case (step_i)
                                STEP_W'(0): begin
                                    ctrl_o.gra          = 1'b1;
                                    ctrl_o.rout         = 1'b1;
                                    ctrl_o.enable[EN_Y] = 1'b1;
                                end
                                STEP_W'(1): begin
                                    ctrl_o.grb          = 1'b1;
                                    ctrl_o.rout         = 1'b1;
                                    ctrl_o.alu_op       = opcode_i;
                                    ctrl_o.enable[EN_Z] = 1'b1;
                                end
                                STEP_W'(2): begin
                                    ctrl_o.bus_select[BS_ZLO] = 1'b1;
                                    ctrl_o.enable[EN_LO]      = 1'b1;
                                end
                                STEP_W'(3): begin
                                    ctrl_o.bus_select[BS_ZHI] = 1'b1;
                                    ctrl_o.enable[EN_HI]      = 1'b1;
                                    last_o                    = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_NEG, OP_NOT: begin
                            if (step_i == STEP_W'(0)) begin
                                ctrl_o.grb          = 1'b1;
                                ctrl_o.rout         = 1'b1;
                                ctrl_o.alu_op       = opcode_i;
                                ctrl_o.enable[EN_Z] = 1'b1;
                            end else if (step_i == STEP_W'(1)) begin
                                ctrl_o.bus_select[BS_ZLO] = 1'b1;
                                ctrl_o.gra                = 1'b1;
                                ctrl_o.rin                = 1'b1;
                                last_o                    = 1'b1;
                            end
                        end
                        // ldi, ld and st share the effective-address computation in E0..E1.
                        OP_LDI, OP_LD, OP_ST: begin
                            if (step_i == STEP_W'(0)) begin
                                ctrl_o.grb          = 1'b1;
                                ctrl_o.baout        = 1'b1;
                                ctrl_o.enable[EN_Y] = 1'b1;
                            end else if (step_i == STEP_W'(1)) begin
                                ctrl_o.bus_select[BS_C] = 1'b1;
                                ctrl_o.alu_op           = ALU_ADD;
                                ctrl_o.enable[EN_Z]     = 1'b1;
                            end else if (step_i == STEP_W'(2)) begin
                                ctrl_o.bus_select[BS_ZLO] = 1'b1;
                                if (opcode_i == OP_LDI) begin
                                    ctrl_o.gra = 1'b1;
                                    ctrl_o.rin = 1'b1;
                                    last_o     = 1'b1;
                                end else begin
                                    ctrl_o.enable[EN_MAR] = 1'b1;
                                end
                            end else if (opcode_i == OP_ST) begin
                                if (step_i == STEP_W'(3)) begin
                                    ctrl_o.gra       = 1'b1;
                                    ctrl_o.rout      = 1'b1;
                                    ctrl_o.write_ram = 1'b1;
                                    last_o           = 1'b1;
                                end
                            end else if (opcode_i == OP_LD) begin
                                if (step_i < LD_CAP) begin
                                    ctrl_o.read_ram = 1'b1;
                                end else if (step_i == LD_CAP) begin
                                    ctrl_o.read_ram       = 1'b1;
                                    ctrl_o.md_read        = 1'b1;
                                    ctrl_o.enable[EN_MDR] = 1'b1;
                                end else if (step_i == LD_LAST) begin
                                    ctrl_o.bus_select[BS_MDR] = 1'b1;
                                    ctrl_o.gra                = 1'b1;
                                    ctrl_o.rin                = 1'b1;
                                    last_o                    = 1'b1;
                                end
                            end
                        end
                        OP_BR: begin
                            case (step_i)
                                STEP_W'(0): begin
                                    ctrl_o.gra            = 1'b1;
                                    ctrl_o.rout           = 1'b1;
                                    ctrl_o.enable[EN_CON] = 1'b1;
                                end
                                STEP_W'(1): begin
                                    ctrl_o.bus_select[BS_PC] = 1'b1;
                                    ctrl_o.enable[EN_Y]      = 1'b1;
                                end
                                STEP_W'(2): begin
                                    ctrl_o.bus_select[BS_C] = 1'b1;
                                    ctrl_o.alu_op           = ALU_ADD;
                                    ctrl_o.enable[EN_Z]     = 1'b1;
                                end
                                STEP_W'(3): begin
                                    ctrl_o.bus_select[BS_ZLO] = conff_i;
                                    ctrl_o.enable[EN_PC]      = conff_i;
                                    last_o                    = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_JR: begin
                            if (step_i == STEP_W'(0)) begin
                                ctrl_o.gra           = 1'b1;
                                ctrl_o.rout          = 1'b1;
                                ctrl_o.enable[EN_PC] = 1'b1;
                                last_o               = 1'b1;
                            end
                        end
                        OP_JAL: begin
                            if (step_i == STEP_W'(0)) begin
                                ctrl_o.bus_select[BS_PC] = 1'b1;
                                ctrl_o.grb               = 1'b1;
                                ctrl_o.rin               = 1'b1;
                            end else if (step_i == STEP_W'(1)) begin
                                ctrl_o.gra           = 1'b1;
                                ctrl_o.rout          = 1'b1;
                                ctrl_o.enable[EN_PC] = 1'b1;
                                last_o               = 1'b1;
                            end
                        end
                        OP_IN, OP_MFHI, OP_MFLO: begin
                            if (step_i == STEP_W'(0)) begin
                                ctrl_o.bus_select[BS_INP] = (opcode_i == OP_IN);
                                ctrl_o.bus_select[BS_HI]  = (opcode_i == OP_MFHI);
                                ctrl_o.bus_select[BS_LO]  = (opcode_i == OP_MFLO);
                                ctrl_o.gra                = 1'b1;
                                ctrl_o.rin                = 1'b1;
                                last_o                    = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            if (step_i == STEP_W'(0)) begin
                                ctrl_o.gra            = 1'b1;
                                ctrl_o.rout           = 1'b1;
                                ctrl_o.enable[EN_OUT] = 1'b1;
                                last_o                = 1'b1;
                            end
                        end
                        // nop, halt and undefined opcodes: a single empty step.
                        default: last_o = (step_i == STEP_W'(0));
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Mini-SRC hardwired control sequencer: phase/step registers,
//               next-step logic and reset gating around control_step_decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import control_pkg::*;
#(
    parameter int RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        CONFFOut,
    input  logic        stop,
    output logic        run,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic        MD_Read,
    output logic [4:0]  Control_Signals
);

    logic [1:0]        phase_q, phase_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              stop_pend_q, stop_pend_d;

    logic [4:0]        w_opcode;
    logic              w_last;
    logic              w_stop_req;
    logic              w_unused_ir;
    ctrl_word_t        w_ctrl;
    ctrl_word_t        w_out;

    assign w_opcode    = ir[31:27];
    assign w_unused_ir = ^ir[26:0];
    // A stop pulse seen anywhere in the instruction is held until the boundary.
    assign w_stop_req  = stop_pend_q | stop;

    control_step_decode #(
        .RAM_WAIT (RAM_WAIT)
    ) u_decode (
        .phase_i  (phase_q),
        .step_i   (step_q),
        .opcode_i (w_opcode),
        .conff_i  (CONFFOut),
        .ctrl_o   (w_ctrl),
        .last_o   (w_last)
    );

    always_comb begin
        phase_d     = phase_q;
        step_d      = step_q;
        stop_pend_d = w_stop_req;
        case (phase_q)
            PH_FETCH: begin
                if (w_last) begin
                    phase_d = PH_EXEC;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            PH_EXEC: begin
                if (w_last) begin
                    phase_d     = ((w_opcode == OP_HALT) || w_stop_req) ? PH_HALT : PH_FETCH;
                    step_d      = '0;
                    stop_pend_d = 1'b0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            PH_HALT: stop_pend_d = 1'b0;
            default: begin
                phase_d     = PH_FETCH;
                step_d      = '0;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            phase_q     <= PH_FETCH;
            step_q      <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            step_q      <= step_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign w_out = (clr || (phase_q == PH_HALT)) ? '0 : w_ctrl;
    assign run   = clr || (phase_q != PH_HALT);

    assign enable          = w_out.enable;
    assign busSelect       = w_out.bus_select;
    assign Gra             = w_out.gra;
    assign Grb             = w_out.grb;
    assign Grc             = w_out.grc;
    assign Rin             = w_out.rin;
    assign Rout            = w_out.rout;
    assign BAout           = w_out.baout;
    assign ReadRAM         = w_out.read_ram;
    assign WriteRAM        = w_out.write_ram;
    assign MD_Read         = w_out.md_read;
    assign Control_Signals = w_out.alu_op;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Directed bench for control_unit, one instance per RAM_WAIT
//               setting (1 and 2), with hand-computed control words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    localparam logic [31:0] EN_HI  = 32'h0001_0000;
    localparam logic [31:0] EN_LO  = 32'h0002_0000;
    localparam logic [31:0] EN_Z   = 32'h0004_0000;
    localparam logic [31:0] EN_Y   = 32'h0008_0000;
    localparam logic [31:0] EN_PC  = 32'h0010_0000;
    localparam logic [31:0] EN_MDR = 32'h0020_0000;
    localparam logic [31:0] EN_IR  = 32'h0100_0000;
    localparam logic [31:0] EN_MAR = 32'h0200_0000;
    localparam logic [31:0] EN_CON = 32'h0800_0000;

    localparam logic [31:0] BS_ZHI = 32'h0004_0000;
    localparam logic [31:0] BS_ZLO = 32'h0008_0000;
    localparam logic [31:0] BS_PC  = 32'h0010_0000;
    localparam logic [31:0] BS_MDR = 32'h0020_0000;
    localparam logic [31:0] BS_C   = 32'h0080_0000;

    // strobe order: {Gra,Grb,Grc,Rin,Rout,BAout,ReadRAM,WriteRAM,MD_Read}
    localparam logic [8:0] S_GRA  = 9'b100000000;
    localparam logic [8:0] S_GRB  = 9'b010000000;
    localparam logic [8:0] S_GRC  = 9'b001000000;
    localparam logic [8:0] S_RIN  = 9'b000100000;
    localparam logic [8:0] S_ROUT = 9'b000010000;
    localparam logic [8:0] S_BA   = 9'b000001000;
    localparam logic [8:0] S_RD   = 9'b000000100;
    localparam logic [8:0] S_MDR  = 9'b000000001;

    localparam logic [4:0] A_ADD = 5'b00011;
    localparam logic [4:0] A_INC = 5'b11111;
    localparam logic [4:0] A_MUL = 5'b10000;

    localparam logic [31:0] IR_ADD  = 32'h1891_8000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_BR   = 32'h9880_0004;
    localparam logic [31:0] IR_MUL  = 32'h8118_0000;
    localparam logic [31:0] IR_LD   = 32'h0088_0005;

    logic        clk = 1'b0;
    logic        clr, CONFFOut, stop;
    logic [31:0] ir;

    logic        run1, gra1, grb1, grc1, rin1, rout1, ba1, rd1, wr1, mdr1;
    logic [31:0] en1, bs1;
    logic [4:0]  alu1;
    logic        run2, gra2, grb2, grc2, rin2, rout2, ba2, rd2, wr2, mdr2;
    logic [31:0] en2, bs2;
    logic [4:0]  alu2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    control_unit #(.RAM_WAIT(1)) u_dut1 (
        .clk(clk), .clr(clr), .ir(ir), .CONFFOut(CONFFOut), .stop(stop),
        .run(run1), .enable(en1), .busSelect(bs1),
        .Gra(gra1), .Grb(grb1), .Grc(grc1), .Rin(rin1), .Rout(rout1), .BAout(ba1),
        .ReadRAM(rd1), .WriteRAM(wr1), .MD_Read(mdr1), .Control_Signals(alu1)
    );

    control_unit #(.RAM_WAIT(2)) u_dut2 (
        .clk(clk), .clr(clr), .ir(ir), .CONFFOut(CONFFOut), .stop(stop),
        .run(run2), .enable(en2), .busSelect(bs2),
        .Gra(gra2), .Grb(grb2), .Grc(grc2), .Rin(rin2), .Rout(rout2), .BAout(ba2),
        .ReadRAM(rd2), .WriteRAM(wr2), .MD_Read(mdr2), .Control_Signals(alu2)
    );

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic chk(input string tag, input int which, input logic [31:0] e_en,
                       input logic [31:0] e_bs, input logic [8:0] e_st,
                       input logic [4:0] e_alu, input logic e_run);
        logic [31:0] o_en, o_bs;
        logic [8:0]  o_st;
        logic [4:0]  o_alu;
        logic        o_run;
        if (which == 2) begin
            o_en = en2; o_bs = bs2; o_alu = alu2; o_run = run2;
            o_st = {gra2, grb2, grc2, rin2, rout2, ba2, rd2, wr2, mdr2};
        end else begin
            o_en = en1; o_bs = bs1; o_alu = alu1; o_run = run1;
            o_st = {gra1, grb1, grc1, rin1, rout1, ba1, rd1, wr1, mdr1};
        end
        cmp({tag, ".enable"}, o_en, e_en);
        cmp({tag, ".busSelect"}, o_bs, e_bs);
        cmp({tag, ".strobes"}, {23'd0, o_st}, {23'd0, e_st});
        cmp({tag, ".alu"}, {27'd0, o_alu}, {27'd0, e_alu});
        cmp({tag, ".run"}, {31'd0, o_run}, {31'd0, e_run});
    endtask

    // Advance to just after the next rising edge; inputs may change here.
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        go();
        #1;
    endtask

    // Checks a full fetch starting in T0; returns in the Tm+1 cycle.
    task automatic fetch(input string tag, input int which, input int rw);
        chk({tag, ".T0"}, which, EN_MAR | EN_Z, BS_PC, 9'd0, A_INC, 1'b1);
        tick();
        chk({tag, ".T1"}, which, EN_PC, BS_ZLO, S_RD, 5'd0, 1'b1);
        for (int i = 1; i < rw; i++) begin
            tick();
            chk({tag, ".Tw"}, which, 32'd0, 32'd0, S_RD, 5'd0, 1'b1);
        end
        tick();
        chk({tag, ".Tm"}, which, EN_MDR, 32'd0, S_RD | S_MDR, 5'd0, 1'b1);
        tick();
        chk({tag, ".Tm1"}, which, EN_IR, BS_MDR, 9'd0, 5'd0, 1'b1);
    endtask

    task automatic br_head(input string tag);
        tick();
        chk({tag, ".E0"}, 1, EN_CON, 32'd0, S_GRA | S_ROUT, 5'd0, 1'b1);
        tick();
        chk({tag, ".E1"}, 1, EN_Y, BS_PC, 9'd0, 5'd0, 1'b1);
        tick();
        chk({tag, ".E2"}, 1, EN_Z, BS_C, 9'd0, A_ADD, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b1; ir = 32'd0; CONFFOut = 1'b0; stop = 1'b0;

        // reset for two cycles
        tick();
        chk("rst1", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b1);
        chk("rst1b", 2, 32'd0, 32'd0, 9'd0, 5'd0, 1'b1);
        tick();
        chk("rst2", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b1);

        // add R1,R2,R3
        go(); clr = 1'b0; ir = IR_ADD; #1;
        fetch("add", 1, 1);
        tick(); chk("add.E0", 1, EN_Y, 32'd0, S_GRB | S_ROUT, 5'd0, 1'b1);
        tick(); chk("add.E1", 1, EN_Z, 32'd0, S_GRC | S_ROUT, A_ADD, 1'b1);
        tick(); chk("add.E2", 1, 32'd0, BS_ZLO, S_GRA | S_RIN, 5'd0, 1'b1);
        tick();

        // second add with a stop pulse during E1
        fetch("add2", 1, 1);
        tick(); chk("add2.E0", 1, EN_Y, 32'd0, S_GRB | S_ROUT, 5'd0, 1'b1);
        go(); stop = 1'b1; #1;
        chk("add2.E1", 1, EN_Z, 32'd0, S_GRC | S_ROUT, A_ADD, 1'b1);
        go(); stop = 1'b0; #1;
        chk("add2.E2", 1, 32'd0, BS_ZLO, S_GRA | S_RIN, 5'd0, 1'b1);
        tick(); chk("stop.halt1", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b0);
        tick(); chk("stop.halt2", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b0);

        // halt opcode
        go(); clr = 1'b1; ir = IR_HALT; #1;
        chk("halt.clr", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b1);
        go(); clr = 1'b0; #1;
        fetch("halt", 1, 1);
        tick(); chk("halt.E0", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt.hold", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b0);
        end
        go(); clr = 1'b1; #1;
        chk("halt.exitclr", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b1);

        // br not taken, then taken
        go(); clr = 1'b0; ir = IR_BR; CONFFOut = 1'b0; #1;
        fetch("br0", 1, 1);
        br_head("br0");
        tick(); chk("br0.E3", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b1);
        go(); CONFFOut = 1'b1; #1;
        fetch("br1", 1, 1);
        br_head("br1");
        tick(); chk("br1.E3", 1, EN_PC, BS_ZLO, 9'd0, 5'd0, 1'b1);

        // mul
        go(); ir = IR_MUL; CONFFOut = 1'b0; #1;
        fetch("mul", 1, 1);
        tick(); chk("mul.E0", 1, EN_Y, 32'd0, S_GRA | S_ROUT, 5'd0, 1'b1);
        tick(); chk("mul.E1", 1, EN_Z, 32'd0, S_GRB | S_ROUT, A_MUL, 1'b1);
        tick(); chk("mul.E2", 1, EN_LO, BS_ZLO, 9'd0, 5'd0, 1'b1);
        tick(); chk("mul.E3", 1, EN_HI, BS_ZHI, 9'd0, 5'd0, 1'b1);

        // ld aborted by clr in E2
        go(); ir = IR_LD; #1;
        fetch("ldab", 1, 1);
        tick(); chk("ldab.E0", 1, EN_Y, 32'd0, S_GRB | S_BA, 5'd0, 1'b1);
        tick(); chk("ldab.E1", 1, EN_Z, BS_C, 9'd0, A_ADD, 1'b1);
        go(); clr = 1'b1; #1;
        chk("ldab.E2clr", 1, 32'd0, 32'd0, 9'd0, 5'd0, 1'b1);
        go(); clr = 1'b0; #1;
        chk("ldab.T0", 1, EN_MAR | EN_Z, BS_PC, 9'd0, A_INC, 1'b1);

        // ld with RAM_WAIT=2 on the second instance
        fetch("ld2", 2, 2);
        tick(); chk("ld2.E0", 2, EN_Y, 32'd0, S_GRB | S_BA, 5'd0, 1'b1);
        tick(); chk("ld2.E1", 2, EN_Z, BS_C, 9'd0, A_ADD, 1'b1);
        tick(); chk("ld2.E2", 2, EN_MAR, BS_ZLO, 9'd0, 5'd0, 1'b1);
        tick(); chk("ld2.E3", 2, 32'd0, 32'd0, S_RD, 5'd0, 1'b1);
        tick(); chk("ld2.E4", 2, 32'd0, 32'd0, S_RD, 5'd0, 1'b1);
        tick(); chk("ld2.E5", 2, EN_MDR, 32'd0, S_RD | S_MDR, 5'd0, 1'b1);
        tick(); chk("ld2.E6", 2, 32'd0, BS_MDR, S_GRA | S_RIN, 5'd0, 1'b1);
        tick(); chk("ld2.T0", 2, EN_MAR | EN_Z, BS_PC, 9'd0, A_INC, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
